// File: rtl/rr_grant_scheduler.sv
// Round-robin resource scheduler: one owner at a time, released by done/request drop.
// Define RR_GRANT_TIMEOUT_EN to add the MAX_HOLD forced-release counter and timeout_o pulse.
module rr_grant_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [NUM_PORTS-1:0]         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int IW = $clog2(NUM_PORTS);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]        id_q, id_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 timeout_q, timeout_d;

  logic [NUM_PORTS-1:0] cand_req;
  logic [IW-1:0]        cand_id [NUM_PORTS];
  logic [IW-1:0]        sel_id;
  logic                 sel_vld;
  logic                 release_own;
  logic                 hold_max;

  // Candidate gi is the port at rotating distance gi+1 from the last owner.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr_q} + (IW+1)'(gi + 1);
    assign cand_id[gi]  = (sum >= (IW+1)'(NUM_PORTS)) ? IW'(sum - (IW+1)'(NUM_PORTS))
                                                       : sum[IW-1:0];
    assign cand_req[gi] = req_i[cand_id[gi]];
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        sel_vld = 1'b1;
        sel_id  = cand_id[k];
      end
    end
  end

  assign release_own = done_i[id_q] | ~req_i[id_q];

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);

  logic [CW-1:0] hold_q, hold_d;

  assign hold_max = (state_q == ST_GRANT) && (hold_q == CW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == ST_GRANT && state_d == ST_GRANT) begin
      hold_d = hold_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign hold_max = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_PORTS'(1) << sel_id;
          id_d    = sel_id;
          ptr_d   = sel_id;
        end
      end
      ST_GRANT: begin
        // A voluntary release in the same cycle as the limit wins: no timeout flag.
        if (release_own || hold_max) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          id_d      = '0;
          timeout_d = hold_max & ~release_own;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= IW'(NUM_PORTS - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign busy_o    = |gnt_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: directed scenarios plus randomized traffic against a grant-level model.
// Build with or without RR_GRANT_TIMEOUT_EN; the model and directed cases follow the same macro.
module tb_rr_grant_scheduler;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  localparam logic [3:0] SEQ30 [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                       4'b0000, 4'b1000, 4'b0000, 4'b0001};

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic [3:0] req_i  = 4'b0;
  logic [3:0] done_i = 4'b0;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic       timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  rr_grant_scheduler #(
    .NUM_PORTS(N),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .done_i   (done_i),
    .gnt_o    (gnt_o),
    .gnt_id_o (gnt_id_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Model state: owner == N means nobody holds the resource; hold counts grant cycles so far.
  typedef struct packed {
    int owner;
    int last;
    int hold;
    bit to;
  } mstate_t;

  function automatic mstate_t rst_state();
    mstate_t s;
    s.owner = N;
    s.last  = N - 1;
    s.hold  = 0;
    s.to    = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic [3:0] r, logic [3:0] d);
    mstate_t n = s;
    n.to = 1'b0;
    if (s.owner == N) begin
      for (int k = 1; k <= N; k++) begin
        int c = (s.last + k) % N;
        if (r[c] && n.owner == N) begin
          n.owner = c;
          n.last  = c;
          n.hold  = 1;
        end
      end
    end else begin
      bit rel    = d[s.owner] || !r[s.owner];
      bit forced = TMO && (s.hold >= MH);
      if (rel || forced) begin
        n.owner = N;
        n.to    = forced && !rel;
      end else begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_out(mstate_t s);
    logic [3:0] g  = (s.owner < N) ? 4'(1 << s.owner) : 4'b0;
    logic [1:0] id = (s.owner < N) ? 2'(s.owner) : 2'd0;
    return {g, id, |g, s.to};
  endfunction

  mstate_t m = rst_state();

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= rst_state();
    else        m <= model_step(m, req_i, done_i);
  end

  always @(negedge clk) begin
    logic [7:0] e;
    e = exp_out(m);
    n_cmp++;
    if ({gnt_o, gnt_id_o, busy_o, timeout_o} !== e) begin
      n_bad++;
      $display("FAIL model @%0t: got gnt=%b id=%0d busy=%b to=%b, expected gnt=%b id=%0d busy=%b to=%b",
               $time, gnt_o, gnt_id_o, busy_o, timeout_o, e[7:4], e[3:2], e[1], e[0]);
    end
  end

  task automatic chk(string nm, logic [3:0] eg, logic eto);
    logic [1:0] eid = 2'($clog2(eg));
    n_cmp++;
    if ({gnt_o, gnt_id_o, busy_o, timeout_o} !== {eg, eid, |eg, eto}) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, expected gnt=%b id=%0d busy=%b to=%b",
               nm, gnt_o, gnt_id_o, busy_o, timeout_o, eg, eid, |eg, eto);
    end else begin
      $display("ok   %s: gnt=%b id=%0d busy=%b to=%b", nm, gnt_o, gnt_id_o, busy_o, timeout_o);
    end
  endtask

  // Leaves the caller at a falling edge with reset just released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    req_i  = 4'b0;
    done_i = 4'b0;
    @(negedge clk);
    chk("in_reset", 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Single owner, done in its third grant cycle.
    do_reset();
    req_i = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("single_c%0d", c), 4'b0001, 1'b0);
    end
    done_i = 4'b0001;
    @(negedge clk);
    done_i = 4'b0;
    chk("single_rel", 4'b0000, 1'b0);
    req_i = 4'b0;

    // All ports requesting, each owner strobes done in its first cycle.
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("rr_all_%0d", i), SEQ30[i], 1'b0);
      done_i = SEQ30[i];
    end
    @(negedge clk);
    done_i = 4'b0;
    req_i  = 4'b0;

    // Wrap from port 1 to port 3 and back to port 1.
    do_reset();
    req_i = 4'b0010;
    @(negedge clk);
    chk("wrap_p1", 4'b0010, 1'b0);
    req_i  = 4'b1010;
    done_i = 4'b0010;
    @(negedge clk);
    done_i = 4'b0;
    chk("wrap_idle", 4'b0000, 1'b0);
    @(negedge clk);
    chk("wrap_p3", 4'b1000, 1'b0);
    done_i = 4'b1000;
    @(negedge clk);
    done_i = 4'b0;
    chk("wrap_idle2", 4'b0000, 1'b0);
    @(negedge clk);
    chk("wrap_p1b", 4'b0010, 1'b0);
    req_i = 4'b0;

`ifdef RR_GRANT_TIMEOUT_EN
    // Held request is cut after MAX_HOLD cycles, then regranted.
    do_reset();
    req_i = 4'b0100;
    for (int c = 1; c <= MH; c++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", c), 4'b0100, 1'b0);
    end
    @(negedge clk);
    chk("hold_timeout", 4'b0000, 1'b1);
    @(negedge clk);
    chk("hold_regrant", 4'b0100, 1'b0);
    for (int c = 2; c <= MH; c++) begin
      @(negedge clk);
      chk($sformatf("hold2_c%0d", c), 4'b0100, 1'b0);
    end
    done_i = 4'b0100;
    @(negedge clk);
    done_i = 4'b0;
    chk("hold_done_at_limit", 4'b0000, 1'b0);
    req_i = 4'b0;
`else
    // No limit: a held request keeps the grant indefinitely.
    do_reset();
    req_i = 4'b0100;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk($sformatf("nolimit_c%0d", c), 4'b0100, 1'b0);
    end
    req_i = 4'b0;
`endif

    // Asynchronous reset in the second cycle of a port 2 grant.
    do_reset();
    req_i = 4'b0100;
    @(negedge clk);
    chk("areset_c1", 4'b0100, 1'b0);
    @(negedge clk);
    chk("areset_c2", 4'b0100, 1'b0);
    #2 reset = 1'b0;
    #1 chk("areset_drop", 4'b0000, 1'b0);
    @(negedge clk);
    req_i = 4'b1111;
    reset = 1'b1;
    @(negedge clk);
    chk("areset_first", 4'b0001, 1'b0);
    done_i = 4'b0001;
    @(negedge clk);
    done_i = 4'b0;

    // Randomized traffic, with occasional mid-cycle reset pulses.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req_i = 4'($urandom);
      done_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of requesters (legal 2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant length in cycles (legal >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, NUM_PORTS, per-port request level, held while the port wants the resource.
REQ-006 The block SHALL have port done_i, input, NUM_PORTS, per-port one-cycle transaction-complete strobe.
REQ-007 The block SHALL have port gnt_o, output, NUM_PORTS, registered one-hot grant, or all zeros when no grant.
REQ-008 The block SHALL have port gnt_id_o, output, $clog2(NUM_PORTS), registered index of the granted port, 0 when no grant.
REQ-009 The block SHALL have port busy_o, output, 1, high exactly when gnt_o is non-zero.
REQ-010 The block SHALL have port timeout_o, output, 1, registered one-cycle pulse flagging a forced release.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one port owns the resource).
REQ-012 In IDLE with req_i non-zero, the block SHALL select the first requesting port searching upward from ptr+1, wrapping at NUM_PORTS-1 to 0, and enter GRANT at the next edge.
REQ-013 On entering GRANT, the block SHALL set gnt_o, gnt_id_o and busy_o for the selected port, load ptr with its index, and clear the hold counter.
REQ-014 In IDLE with req_i zero, the block SHALL stay in IDLE with all outputs zero.
REQ-015 In GRANT, gnt_o SHALL stay constant regardless of other ports' req_i or done_i.
REQ-016 In GRANT, the block SHALL release to IDLE at the next edge when done_i[owner]=1 or req_i[owner]=0.
REQ-017 done_i bits of non-owning ports SHALL be ignored in all states.
REQ-018 After every release, gnt_o SHALL be zero for exactly one cycle (the IDLE arbitration cycle) before any new grant.
REQ-019 Request-to-grant latency from an IDLE cycle with a visible request SHALL be one cycle.
REQ-020 The hold counter SHALL be $clog2(MAX_HOLD) bits wide, equal 0 in the first GRANT cycle, and increment once per GRANT cycle.
REQ-021 When the counter equals MAX_HOLD-1 in GRANT, the block SHALL release to IDLE at the next edge, so a grant lasts at most MAX_HOLD cycles.
REQ-022 timeout_o SHALL be high for the single IDLE cycle following a counter-forced release, and SHALL stay low if done_i[owner] or req_i[owner] release occurs in the same cycle.
REQ-023 Under continuously asserted requests, the block SHALL grant every requesting port once before any port is granted twice.

Reset
REQ-024 While reset=0, the block SHALL hold the FSM in IDLE and force gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, hold counter=0 and ptr=NUM_PORTS-1, independent of clk.
REQ-025 Reset asserted during GRANT SHALL drop the grant immediately, with no timeout_o pulse.
REQ-026 After reset release, the first grant SHALL go to the lowest-indexed requesting port.

Configuration
REQ-027 With macro RR_GRANT_TIMEOUT_EN defined, the hold counter and REQ-020..REQ-022 SHALL be implemented.
REQ-028 Without RR_GRANT_TIMEOUT_EN, the block SHALL omit the hold counter, release only per REQ-016, and tie timeout_o to 0; MAX_HOLD is then unused.

Verification
REQ-029 The bench SHALL cover: after reset, req_i=0001 held, done_i=0001 in the 3rd grant cycle -> gnt_o=0001 and gnt_id_o=0 for 3 cycles, then 0000.
REQ-030 The bench SHALL cover: req_i=1111 held, owner strobes done_i in its first grant cycle -> gnt_o sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-031 The bench SHALL cover: port 1 granted and released with req_i=1010 -> next grant is 1000 (port 3), then 0010.
REQ-032 The bench SHALL cover: with RR_GRANT_TIMEOUT_EN and MAX_HOLD=4, req_i=0100 held without done_i -> gnt_o=0100 for 4 cycles, then a 0000 cycle with timeout_o=1, then regrant 0100.
REQ-033 The bench SHALL cover: reset pulled low in the 2nd cycle of a port 2 grant -> gnt_o=0000 asynchronously; after release with req_i=1111, first grant is 0001.
REQ-034 The bench SHALL cover: without RR_GRANT_TIMEOUT_EN, req_i=0100 held for 40 cycles with no done_i -> gnt_o=0100 throughout and timeout_o=0.
